uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver; the downstream counterpart of the UART transmitter. It consumes the serial `rxd` line driven by a remote `txd` and delivers parallel words on a valid/ready interface toward the AXI-Lite register block.
- Uses the same `prescale` convention as TX: clock cycles per bit. Frame format: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
- Samples at mid-bit and reports framing and overrun errors.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- rxd  input  1  serial line, asynchronous to clk, idle high
- prescale  input  16  clk cycles per bit; must be >= 4; latched at start-bit detect
- rx_data  output  DATA_WIDTH  received word; stable while rx_valid=1
- rx_valid  output  1  word available; held until accepted
- rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready
- rx_busy  output  1  high from start-bit detect until return to IDLE
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overrun_error  output  1  one-cycle pulse: word completed while the previous word was still unaccepted

Behaviour:
- Reset (async assert, sync release):
  - Outputs: rx_data=0, rx_valid=0, rx_busy=0, frame_error=0, overrun_error=0.
  - Internals: state=IDLE, timer=0, bit_cnt=0.
  - Synchronizer flops preset to 1.
- Input sync: rxd passes through a 2-flop synchronizer (`rxd_s`). A third flop (`rxd_q`) holds the previous `rxd_s` for edge detection. All decisions use `rxd_s`.
- Error pulses: frame_error and overrun_error default to 0 every cycle.
- IDLE:
  - Trigger: falling edge (`rxd_q`=1, `rxd_s`=0).
  - On trigger: latch prescale; timer <= (prescale>>1)-1; rx_busy <= 1; go to START.
  - A line held low never re-triggers. This gives break immunity.
- START:
  - Count timer down to 0.
  - At 0, if `rxd_s`=0: timer <= prescale_latched-1, bit_cnt <= 0, go to DATA.
  - At 0, if `rxd_s`=1 (glitch): go to IDLE, rx_busy <= 0, no flags raised.
- DATA:
  - At each timer=0: shift `rxd_s` into the MSB of the shift register (LSB-first reception), bit_cnt++, reload timer.
  - After the DATA_WIDTH-th sample, go to STOP with timer reloaded.
- STOP, at timer=0:
  - If `rxd_s`=1: the word is complete (see output handshake).
  - If `rxd_s`=0: frame_error <= 1 for one cycle; the word is discarded.
  - In both cases: go to IDLE, rx_busy <= 0.
- Output handshake:
  - Accept: when rx_valid & rx_ready, rx_valid clears next cycle.
  - Word complete with rx_valid=0, or with rx_valid=1 & rx_ready=1 in the same cycle: rx_data <= word, rx_valid <= 1 next cycle. Back-to-back words are lossless.
  - Word complete with rx_valid=1 & rx_ready=0: overrun_error pulses; the new word is dropped; rx_data and rx_valid keep the old word.
- Latency:
  - Start detect: 3 clk after the line falls (2 sync flops + edge register).
  - rx_valid rises 1 clk after the stop-bit mid-sample.
- Prescale: changes to `prescale` mid-frame are ignored. The latched value is used until IDLE.
- Reset mid-frame: returns immediately to the reset state. The partial word is lost, with no error pulse after release.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision (start verify, data, stop) is the 2-of-3 majority of `rxd_s` sampled at timer = 1, 0 and the cycle after 0.
  - The decision and state transition occur one cycle later than without the macro.
  - prescale must be >= 8.
- Undefined: single sample at timer=0 as described above; no extra registers.

Test Plan:
- prescale=16, send 0x55 then 0xA3 with rx_ready tied 1 -> two rx_valid pulses with rx_data 0x55 then 0xA3; no error pulses; rx_busy high for about 160 clk per frame.
- prescale=16, 4-clk low glitch on idle rxd -> START aborts, rx_valid stays 0, no error pulses, rx_busy returns to 0.
- prescale=16, send 0x3C with the stop bit forced low -> frame_error one-cycle pulse, rx_valid stays 0. Line held low afterwards -> no new frame starts until rxd returns high and falls again.
- rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 with rx_valid held; overrun_error pulses at the end of the second frame. Raise rx_ready -> 0x11 accepted, rx_valid clears.
- prescale=10 latched, change prescale to 40 mid-frame, send 0xF0 -> 0xF0 received correctly at the 10-cycle bit rate.
- Assert rst_n low mid-DATA, release, send 0x81 -> all outputs 0 during reset; the next frame yields 0x81 with no errors.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rxd, mid-bit sampling, valid/ready output with framing/overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority voting per bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_busy,
    output logic                  frame_error,
    output logic                  overrun_error
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rxdS;
    logic                  r_rxdQ;
    logic [15:0]           r_prescale;
    logic [15:0]           r_timer;
    logic [3:0]            r_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shiftNext;
    logic                  w_tick;
    logic                  w_bit;
    logic [15:0]           w_reload;

    // Flops preset to idle-high so release from reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxdS  <= 1'b1;
            r_rxdQ  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxdS  <= r_sync1;
            r_rxdQ  <= r_rxdS;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_sampA;
    logic r_sampB;
    logic r_decide;

    // Votes on samples at timer=1, timer=0 and the cycle after; reload is one shorter to keep the bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampA  <= 1'b0;
            r_sampB  <= 1'b0;
            r_decide <= 1'b0;
        end else begin
            r_decide <= (r_state != IDLE) && (r_timer == 16'd0) && !r_decide;
            if (r_timer == 16'd1)
                r_sampA <= r_rxdS;
            if ((r_timer == 16'd0) && !r_decide)
                r_sampB <= r_rxdS;
        end
    end

    assign w_tick   = r_decide;
    assign w_bit    = (r_sampA & r_sampB) | (r_sampA & r_rxdS) | (r_sampB & r_rxdS);
    assign w_reload = r_prescale - 16'd2;
`else
    assign w_tick   = (r_timer == 16'd0);
    assign w_bit    = r_rxdS;
    assign w_reload = r_prescale - 16'd1;
`endif

    always_comb begin
        w_shiftNext = r_shift >> 1;
        w_shiftNext[DATA_WIDTH-1] = w_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prescale    <= 16'd0;
            r_timer       <= 16'd0;
            r_bitCnt      <= 4'd0;
            r_shift       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_busy       <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if ((r_state != IDLE) && !w_tick && (r_timer != 16'd0))
                r_timer <= r_timer - 16'd1;

            case (r_state)
                IDLE: begin
                    // Edge-triggered so a held-low (break) line cannot restart a frame.
                    if (r_rxdQ && !r_rxdS) begin
                        r_prescale <= prescale;
                        r_timer    <= (prescale >> 1) - 16'd1;
                        rx_busy    <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (!w_bit) begin
                            r_timer  <= w_reload;
                            r_bitCnt <= 4'd0;
                            r_state  <= DATA;
                        end else begin
                            rx_busy <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift  <= w_shiftNext;
                        r_bitCnt <= r_bitCnt + 4'd1;
                        r_timer  <= w_reload;
                        if (r_bitCnt == 4'(DATA_WIDTH - 1))
                            r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_bit) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= r_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_error <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                        rx_busy <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
